// File: rtl/monitor_uart_tx.sv
// Monitoring sample serializer: 4-entry FIFO feeding an 8N1 UART transmitter.
// Back-to-back frames are sent without an idle gap while samples are queued.
module monitor_uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  input  logic       clr_ovf,
  output logic       tx,
  output logic       busy,
  output logic       overflow,
  output logic [2:0] fifo_count
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0] state;
  logic [7:0] bit_cnt;
  logic [2:0] bit_idx;
  logic [7:0] shreg;
  logic [1:0] wptr, rptr;
  logic [7:0] mem [4];
  logic       push, pop, bit_end;

  assign data_ready = (fifo_count < 3'd4);
  assign busy       = (state != IDLE);
  assign bit_end    = (bit_cnt == 8'(CLKS_PER_BIT - 1));
  assign push       = data_valid && data_ready && reset;
  // Pop decisions use the registered count, so a same-cycle push is never popped.
  assign pop        = (fifo_count != 3'd0) &&
                      ((state == IDLE) || ((state == STOP) && bit_end));

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      tx         <= 1'b1;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 2'd1;
      if (pop)  rptr <= rptr + 2'd1;
      fifo_count <= fifo_count + {2'b0, push} - {2'b0, pop};

      // Set wins over clear.
      if (data_valid && !data_ready) overflow <= 1'b1;
      else if (clr_ovf)              overflow <= 1'b0;

      case (state)
        IDLE: begin
          bit_cnt <= '0;
          if (pop) begin
            shreg <= mem[rptr];
            state <= START;
            tx    <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            state   <= DATA;
            tx      <= shreg[0];
          end else bit_cnt <= bit_cnt + 8'd1;
        end
        DATA: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shreg   <= shreg >> 1;
              tx      <= shreg[1];
            end
          end else bit_cnt <= bit_cnt + 8'd1;
        end
        default: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (pop) begin
              shreg <= mem[rptr];
              state <= START;
              tx    <= 1'b0;
            end else begin
              state <= IDLE;
              tx    <= 1'b1;
            end
          end else bit_cnt <= bit_cnt + 8'd1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_monitor_uart_tx.sv
// Directed bench for monitor_uart_tx with CLKS_PER_BIT = 4.
module tb_monitor_uart_tx;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       clr_ovf;
  logic       tx;
  logic       busy;
  logic       overflow;
  logic [2:0] fifo_count;

  int checks = 0;
  int errors = 0;

  monitor_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .clr_ovf(clr_ovf), .tx(tx), .busy(busy),
    .overflow(overflow), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then settle so outputs reflect that edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check tx/busy over a frame starting at frame cycle first; ends on cycle 40.
  task automatic check_frame(input logic [7:0] b, input int first);
    logic [9:0] bits;
    bits = {1'b1, b, 1'b0};
    for (int i = first; i < 10 * CPB; i++) begin
      chk($sformatf("tx_%02h_c%0d", b, i), {7'b0, tx}, {7'b0, bits[i / CPB]});
      chk($sformatf("busy_%02h_c%0d", b, i), {7'b0, busy}, 8'd1);
      step();
    end
  endtask

  task automatic push(input logic [7:0] d);
    data_in = d; data_valid = 1'b1;
    step();
    data_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; data_in = 8'h00; data_valid = 1'b1; clr_ovf = 1'b0;
    step(); step();
    chk("rst_tx", {7'b0, tx}, 8'd1);
    chk("rst_busy", {7'b0, busy}, 8'd0);
    chk("rst_count", {5'b0, fifo_count}, 8'd0);
    chk("rst_ovf", {7'b0, overflow}, 8'd0);
    chk("rst_ready", {7'b0, data_ready}, 8'd1);
    data_valid = 1'b0; reset = 1'b1;
    step();
    chk("rst_nopush", {5'b0, fifo_count}, 8'd0);

    // Single 0xA5 frame, 1-cycle latency, busy exactly 40 cycles.
    push(8'hA5);
    chk("a5_count", {5'b0, fifo_count}, 8'd1);
    chk("a5_tx_pre", {7'b0, tx}, 8'd1);
    chk("a5_busy_pre", {7'b0, busy}, 8'd0);
    step();
    chk("a5_count_pop", {5'b0, fifo_count}, 8'd0);
    check_frame(8'hA5, 0);
    chk("a5_busy_end", {7'b0, busy}, 8'd0);
    chk("a5_tx_end", {7'b0, tx}, 8'd1);
    step(); step();

    // Back-to-back 0x00 / 0xFF without idle gap.
    data_valid = 1'b1; data_in = 8'h00; step();
    data_in = 8'hFF; step();
    data_valid = 1'b0;
    chk("b2b_count", {5'b0, fifo_count}, 8'd1);
    check_frame(8'h00, 0);
    check_frame(8'hFF, 0);
    chk("b2b_busy_end", {7'b0, busy}, 8'd0);
    step();

    // Six consecutive pushes: the sixth drops and sets overflow.
    data_valid = 1'b1;
    data_in = 8'h11; step();
    data_in = 8'h22; step();
    chk("q_count2", {5'b0, fifo_count}, 8'd1);
    data_in = 8'h33; step();
    data_in = 8'h44; step();
    data_in = 8'h55; step();
    chk("q_full", {5'b0, fifo_count}, 8'd4);
    chk("q_ready0", {7'b0, data_ready}, 8'd0);
    data_in = 8'h66; step();
    data_valid = 1'b0;
    chk("q_ovf", {7'b0, overflow}, 8'd1);
    chk("q_count_drop", {5'b0, fifo_count}, 8'd4);
    check_frame(8'h11, 4);
    check_frame(8'h22, 0);
    check_frame(8'h33, 0);
    check_frame(8'h44, 0);
    check_frame(8'h55, 0);
    chk("q_busy_end", {7'b0, busy}, 8'd0);
    chk("q_count_end", {5'b0, fifo_count}, 8'd0);

    // Clear then a simultaneous drop+clear: set wins.
    clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
    chk("ovf_clr", {7'b0, overflow}, 8'd0);
    data_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data_in = 8'(i); step();
    end
    chk("ovf_full", {7'b0, data_ready}, 8'd0);
    clr_ovf = 1'b1; step();
    chk("ovf_set_wins", {7'b0, overflow}, 8'd1);
    data_valid = 1'b0; step();
    clr_ovf = 1'b0;
    chk("ovf_cleared", {7'b0, overflow}, 8'd0);
    reset = 1'b0; step(); reset = 1'b1;
    chk("mid_rst_count", {5'b0, fifo_count}, 8'd0);
    step();

    // Reset during data bit 3 with two samples queued aborts everything.
    data_valid = 1'b1;
    data_in = 8'h0F; step();
    data_in = 8'hC3; step();
    data_in = 8'h3C; step();
    data_valid = 1'b0;
    chk("ab_count", {5'b0, fifo_count}, 8'd2);
    for (int i = 0; i < 4 * CPB + 1; i++) step();
    chk("ab_busy_pre", {7'b0, busy}, 8'd1);
    reset = 1'b0; step(); reset = 1'b1;
    chk("ab_tx", {7'b0, tx}, 8'd1);
    chk("ab_busy", {7'b0, busy}, 8'd0);
    chk("ab_count0", {5'b0, fifo_count}, 8'd0);
    chk("ab_ready", {7'b0, data_ready}, 8'd1);
    for (int i = 0; i < 12 * CPB; i++) begin
      step();
      chk($sformatf("ab_idle_c%0d", i), {6'b0, busy, ~tx}, 8'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
